// File: rtl/rvfi_dmem_responder.sv
// rvfi_dmem_responder: behavioural data memory with stallable fixed latency and an RVFI-style memory trace
module rvfi_dmem_responder #(
    parameter int XLEN       = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN/8-1:0] mem_wstrb,
    input  logic              stall,
    output logic              mem_ready,
    output logic [XLEN-1:0]   mem_rdata,
    output logic              trc_valid,
    output logic [7:0]        trc_order,
    output logic [XLEN-1:0]   trc_addr,
    output logic [XLEN/8-1:0] trc_rmask,
    output logic [XLEN/8-1:0] trc_wmask,
    output logic [XLEN-1:0]   trc_rdata,
    output logic [XLEN-1:0]   trc_wdata
);
    localparam int NB    = XLEN / 8;
    localparam int OFF   = $clog2(NB);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [NB-1:0]         wstrb_q, wstrb_d;
    logic [7:0]            order_q;
    logic [DEPTH-1:0]      written_q;
    logic [XLEN-1:0]       mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic [XLEN-1:0]       word;
    logic [XLEN-1:0]       lane_bits;
    logic                  resp;
    logic                  is_load;

    assign idx     = addr_q[OFF +: DEPTH_LOG2];
    assign word    = written_q[idx] ? mem_q[idx] : '0;
    assign resp    = state_q == S_RESP;
    assign is_load = wstrb_q == '0;

    for (genvar g = 0; g < NB; g++) begin : g_lane
        assign lane_bits[g*8 +: 8] = {8{wstrb_q[g]}};
    end

    assign mem_ready = resp;
    assign mem_rdata = (resp && is_load) ? word : '0;

    // Request latching, latency countdown with stall freeze, and abort on dropped valid
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    cnt_d   = 4'(LATENCY);
                    state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!mem_valid) begin
                    state_d = S_IDLE;
                end else if (!stall) begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_q == 4'd1) ? S_RESP : S_WAIT;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, written flags, order counter and registered trace record
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            order_q   <= '0;
            written_q <= '0;
            trc_valid <= 1'b0;
            trc_order <= '0;
            trc_addr  <= '0;
            trc_rmask <= '0;
            trc_wmask <= '0;
            trc_rdata <= '0;
            trc_wdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            trc_valid <= resp;
            if (resp) begin
                order_q   <= order_q + 8'd1;
                trc_order <= order_q;
                trc_addr  <= addr_q & ~XLEN'(NB - 1);
                trc_rmask <= is_load ? '1 : '0;
                trc_wmask <= wstrb_q;
                trc_rdata <= is_load ? word : '0;
                trc_wdata <= wdata_q & lane_bits;
                if (!is_load) written_q[idx] <= 1'b1;
            end
        end
    end

    // Lane-merged store; unwritten words merge against zero so stale array contents never leak
    always_ff @(posedge clk) begin
        if (resp && !is_load) mem_q[idx] <= (wdata_q & lane_bits) | (word & ~lane_bits);
    end
endmodule

// File: tb/tb_rvfi_dmem_responder.sv
// tb_rvfi_dmem_responder: directed scoreboard bench for the data-memory responder
module tb_rvfi_dmem_responder;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready, trc_valid;
    logic [31:0] mem_rdata, trc_addr, trc_rdata, trc_wdata;
    logic [7:0]  trc_order;
    logic [3:0]  trc_rmask, trc_wmask;

    typedef struct {
        logic [7:0]  order;
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        logic [31:0] wdata;
    } rec_t;

    rec_t        sb[$];
    logic [31:0] mdl [64];
    bit          wr [64];
    int          exp_order = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    rvfi_dmem_responder dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .stall(stall),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .trc_valid(trc_valid),
        .trc_order(trc_order), .trc_addr(trc_addr), .trc_rmask(trc_rmask),
        .trc_wmask(trc_wmask), .trc_rdata(trc_rdata), .trc_wdata(trc_wdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(mem_ready), 0);
        chk({tag, "_rdata"}, mem_rdata, 0);
        chk({tag, "_tvalid"}, 32'(trc_valid), 0);
        chk({tag, "_torder"}, 32'(trc_order), 0);
        chk({tag, "_taddr"}, trc_addr, 0);
        chk({tag, "_trmask"}, 32'(trc_rmask), 0);
        chk({tag, "_twmask"}, 32'(trc_wmask), 0);
        chk({tag, "_trdata"}, trc_rdata, 0);
        chk({tag, "_twdata"}, trc_wdata, 0);
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int stalls);
        logic [5:0]  ix;
        logic [31:0] old, exp_rd, exp_wd;
        int          lat;
        bit          seen;
        rec_t        r, got;
        ix     = a[7:2];
        old    = wr[ix] ? mdl[ix] : 32'h0;
        exp_rd = (s == 0) ? old : 32'h0;
        exp_wd = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) exp_wd[b*8 +: 8] = d[b*8 +: 8];
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            tick;
            lat++;
            seen  = mem_ready;
            stall = !seen && lat <= stalls;
        end
        stall = 1'b0;
        chk("latency", lat, 3 + stalls);
        chk("mem_rdata", mem_rdata, exp_rd);
        chk("trc_early", 32'(trc_valid), 0);
        r.order = 8'(exp_order);
        r.addr  = {a[31:2], 2'b00};
        r.rmask = (s == 0) ? 4'hF : 4'h0;
        r.wmask = s;
        r.rdata = exp_rd;
        r.wdata = exp_wd;
        sb.push_back(r);
        if (s != 0) begin
            for (int b = 0; b < 4; b++) if (s[b]) old[b*8 +: 8] = d[b*8 +: 8];
            mdl[ix] = old;
            wr[ix]  = 1'b1;
        end
        exp_order = (exp_order + 1) % 256;
        mem_valid = 1'b0;
        tick;
        chk("ready_pulse", 32'(mem_ready), 0);
        chk("trc_valid", 32'(trc_valid), 1);
        got = sb.pop_front();
        chk("trc_order", 32'(trc_order), 32'(got.order));
        chk("trc_addr", trc_addr, got.addr);
        chk("trc_rmask", 32'(trc_rmask), 32'(got.rmask));
        chk("trc_wmask", 32'(trc_wmask), 32'(got.wmask));
        chk("trc_rdata", trc_rdata, got.rdata);
        chk("trc_wdata", trc_wdata, got.wdata);
    endtask

    initial begin
        logic [3:0]  s;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) wr[i] = 1'b0;
        tick;
        tick;
        chk_zero("reset");
        resetn = 1'b1;
        tick;
        access(32'h10, 32'hDEADBEEF, 4'hF, 0);
        access(32'h13, 32'h0, 4'h0, 0);
        access(32'h10, 32'h0000AA00, 4'h2, 0);
        access(32'h10, 32'h0, 4'h0, 0);
        access(32'h22, 32'h11223344, 4'h5, 0);
        access(32'h20, 32'h0, 4'h0, 0);
        access(32'h40, 32'h0, 4'h0, 3);
        mem_valid = 1'b1;
        mem_addr  = 32'h44;
        mem_wdata = 32'hCAFEF00D;
        mem_wstrb = 4'hF;
        tick;
        mem_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("abort_ready", 32'(mem_ready), 0);
            chk("abort_trc", 32'(trc_valid), 0);
        end
        access(32'h44, 32'h0, 4'h0, 0);
        access(32'h100, 32'h5A5AC3C3, 4'hF, 0);
        access(32'h000, 32'h0, 4'h0, 0);
        for (int k = 0; k < 256; k++) begin
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) s = 4'h0;
            a = 32'($urandom_range(0, 1023));
            access(a, $urandom, s, (k % 17 == 0) ? 2 : 0);
        end
        mem_valid = 1'b1;
        mem_addr  = 32'h10;
        mem_wstrb = 4'h0;
        tick;
        resetn = 1'b0;
        #1;
        chk_zero("midreset");
        mem_valid = 1'b0;
        tick;
        resetn = 1'b1;
        for (int i = 0; i < 64; i++) wr[i] = 1'b0;
        exp_order = 0;
        tick;
        access(32'h10, 32'h0, 4'h0, 0);
        access(32'h100, 32'h0, 4'h0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
